fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage that drains the synchronous FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one byte, frames it as asynchronous serial (start bit, data LSB first, optional even parity, stop bit(s)) and shifts it out on a single line at a fixed clocks-per-bit rate. It is the consumer on the FIFO read port: it drives `rq`, and samples `r_data`/`empty`.

## Interface
- `data_width`, 8: bits per character; equals the FIFO data width.
- `clks_per_bit`, 16: clock cycles per serial bit; must be >= 2.
- `parity_en`, 0: 1 inserts an even-parity bit after the data bits.
- `stop_bits`, 1: number of stop bits; legal values are 1 or 2.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: permits starting a new frame. It does not abort a frame already in progress.
- `empty`, input, 1: FIFO empty flag.
- `r_data`, input, `data_width`: FIFO read data. It is valid in the cycle after the edge that accepted `rq`.
- `rq`, output, 1: FIFO pop request. It is combinational.
- `txd`, output, 1: serial line. Idle level is 1.
- `busy`, output, 1: high from the pop until the end of the last stop bit.
- `frame_done`, output, 1: single-cycle pulse in the last cycle of the last stop bit.

## Operation
- The states are IDLE, LOAD, START, DATA, PARITY, STOP. They are defined in the package as an enum.
- **IDLE**
  - `rq = en & ~empty`. No other state asserts `rq`.
  - If `rq` is high, go to LOAD at the next edge.
- **LOAD** (one cycle)
  - Capture `r_data` into the shift register.
  - Compute parity as the XOR of the captured byte.
  - Go to START.
- **START**: `txd=0` for `clks_per_bit` cycles, then go to DATA.
- **DATA**
  - `txd` = shift register bit 0 for `clks_per_bit` cycles per bit.
  - Shift right after each bit.
  - After bit `data_width-1`, go to PARITY if `parity_en`, otherwise go to STOP.
- **PARITY**
  - `txd` = even-parity bit for `clks_per_bit` cycles.
  - The bit is chosen so that the data bits plus the parity bit contain an even number of ones.
- **STOP**
  - `txd=1` for `stop_bits*clks_per_bit` cycles.
  - `frame_done` pulses in the final cycle.
  - Then go to IDLE.
- **Counters**
  - Baud counter: `$clog2(clks_per_bit)` bits, counting 0..`clks_per_bit-1`. It clears on every state entry.
  - Bit index: `$clog2(data_width)` bits.
  - Stop counter: 1 bit.
- **`busy`**: high in every state except IDLE.
- **`txd` glitch-free**: `txd` is driven from a register and is never combinational.
- **Boundary: FIFO empty**: the block stays in IDLE with `txd=1` and `rq=0`.
- **Boundary: `en` falls mid-frame**: the frame completes. The block then holds in IDLE.
- **Boundary: `empty` changes after the pop**: ignored. The byte is already captured.
- **Boundary: back-to-back frames**: if the FIFO is still non-empty after STOP, `rq` asserts in the first IDLE cycle.
- **Boundary: reset mid-frame**
  - The FIFO pop has already happened, so that byte is lost; this is the intended behaviour.
  - On the reset edge, the state goes to IDLE and `txd` goes to 1.

## Timing
- **Reset values**: `txd=1`, `busy=0`, `frame_done=0`, state IDLE, all counters 0, shift register 0. `rq=0` while `rst` is high.
- **Pop to start bit**: if `rq` is high at edge E0, the block is in LOAD after E0 and START after E1, so `txd` falls at E1 + register delay.
- **Frame length** (from the first start-bit cycle): `(1 + data_width + parity_en + stop_bits) * clks_per_bit` cycles.
- **Inter-frame gap**: 2 cycles of `txd=1` (IDLE and LOAD) in addition to the stop bits, when data is continuously available.
- **Pop rate**: at most one pop per frame. `rq` is never high on two consecutive cycles.

## Structure
- **Package `fifo_uart_pkg`**: state enum `tx_state_t`, an `even_parity` function, and a localparam for the counter-width helper.
- **Sub-module `fifo_uart_baud`**
  - Baud counter with a `clear` input and a `tick` output. `tick` is high in the last cycle of each bit.
  - The FSM uses `tick` to advance.
- **Top level**: the FSM, shift register and `txd` register. It is instantiated beside the FIFO, with `rq`, `r_data` and `empty` wired point-to-point.

## Test plan
- **Single byte**
  - Setup: `clks_per_bit=4`, `parity_en=0`; FIFO holds 0x55.
  - Required: `rq` pulses once. `txd` reads 0 then 1,0,1,0,1,0,1,0 then 1, each level held 4 cycles. `frame_done` pulses once. Start-bit to stop-end is 40 cycles.
- **Even parity**
  - Setup: `parity_en=1`.
  - Required: byte 0x07 gives a parity bit of 1; byte 0x03 gives a parity bit of 0. Frame length is 44 cycles.
- **Back-to-back**
  - Setup: push 0x10, 0x20, 0x30 and hold `en=1`.
  - Required: exactly 3 `rq` pulses. Frames appear in FIFO order with a 2-cycle idle gap between frames. `empty` rises after the third pop.
- **Enable**
  - Stimulus: drop `en` during frame 1 with 0xA5 and 0x5A queued.
  - Required: 0xA5 completes, and no further `rq` occurs. Raising `en` again sends 0x5A.
- **Reset mid-DATA**
  - Stimulus: assert `rst` for 1 cycle at bit 3.
  - Required: on the next edge `txd=1`, `busy=0`, state IDLE. The next FIFO byte is sent as a complete, correct frame.
- **Two stop bits**
  - Setup: `stop_bits=2` with `clks_per_bit=2`.
  - Required: the stop high time is 4 cycles, and `frame_done` aligns with its last cycle.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    // Counters never shrink below one bit, even for a count range of 1.
    localparam int MIN_CNT_W = 1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : MIN_CNT_W;
    endfunction

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fifo_uart_baud.sv
// Baud counter: tick marks the last clock of each serial bit period.
module fifo_uart_baud
    import fifo_uart_pkg::*;
#(
    parameter int clks_per_bit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_w(clks_per_bit);
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and shifts them out as async serial frames
// (start, LSB-first data, optional even parity, 1 or 2 stop bits).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int clks_per_bit = 16,
    parameter int parity_en    = 0,
    parameter int stop_bits    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [data_width-1:0] r_data,
    output logic                  rq,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_W = cnt_w(data_width);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_width - 1);
    localparam logic STOP_LAST = 1'(stop_bits - 1);

    tx_state_t             state_q, state_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  tick;

    // Counter restarts on every state change so each state owns whole bit periods.
    fifo_uart_baud #(
        .clks_per_bit(clks_per_bit)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear((state_d != state_q) || (state_q == IDLE)),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (rq) state_d = LOAD;
            end
            LOAD: begin
                shift_d = r_data;
                par_d   = even_parity(64'(r_data));
                state_d = START;
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (parity_en != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from the next-state view so the line changes with the state.
    always_comb begin
        rq         = (state_q == IDLE) && en && !empty && !rst;
        busy       = (state_q != IDLE);
        frame_done = (state_q == STOP) && tick && (stop_q == STOP_LAST);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations, a FIFO model per instance and a serial-line scoreboard.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en_v    [3];
    logic       empty_v [3];
    logic [7:0] rd      [3];
    logic       rq_v    [3];
    logic       txd_v   [3];
    logic       busy_v  [3];
    logic       fd_v    [3];

    logic [7:0] fq [3][$];
    exp_t       exp_q [$];

    bit pop_pend [3];
    bit rq_prev  [3];
    int rq_cnt   [3];
    int consec   [3];

    int checks = 0;
    int errors = 0;
    int en_drop_cnt = 0;

    fifo_uart_tx #(.data_width(8), .clks_per_bit(4), .parity_en(0), .stop_bits(1)) u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .empty(empty_v[0]), .r_data(rd[0]),
        .rq(rq_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    fifo_uart_tx #(.data_width(8), .clks_per_bit(4), .parity_en(1), .stop_bits(1)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .empty(empty_v[1]), .r_data(rd[1]),
        .rq(rq_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    fifo_uart_tx #(.data_width(8), .clks_per_bit(2), .parity_en(0), .stop_bits(2)) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .empty(empty_v[2]), .r_data(rd[2]),
        .rq(rq_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rq_v[i]) rq_cnt[i] <= rq_cnt[i] + 1;
            if (rq_v[i] && rq_prev[i]) consec[i] <= consec[i] + 1;
            rq_prev[i]  <= rq_v[i];
            pop_pend[i] <= rq_v[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cpb_of(input int s);
        return (s == 2) ? 2 : 4;
    endfunction
    function automatic int par_of(input int s);
        return (s == 1) ? 1 : 0;
    endfunction
    function automatic int stop_of(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and serve any FIFO pop accepted on the rising edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (pop_pend[i] && fq[i].size() > 0) rd[i] = fq[i].pop_front();
            empty_v[i] = (fq[i].size() == 0);
        end
        if (en_drop_cnt > 0) begin
            en_drop_cnt--;
            if (en_drop_cnt == 0) en_v[0] = 1'b0;
        end
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic p, input int len);
        exp_t e;
        e.data = b;
        e.par  = p;
        e.len  = len;
        fq[s].push_back(b);
        empty_v[s] = 1'b0;
        exp_q.push_back(e);
    endtask

    // Decode one frame from txd of instance s and compare it with the scoreboard head.
    task automatic recv(input int s, input int exp_gap);
        int cpb, np, ns, total, t, slot, glitch, fd_cnt, fd_pos;
        logic [7:0] dat;
        logic pbit, first_v, v;
        exp_t e;
        cpb = cpb_of(s); np = par_of(s); ns = stop_of(s);
        total = (9 + np + ns) * cpb;
        t = 0; glitch = 0; fd_cnt = 0; fd_pos = -1; dat = '0; pbit = 1'b0; first_v = 1'b1;
        while (txd_v[s] !== 1'b0 && t < 400) begin
            step();
            t++;
        end
        chk("start_seen", 32'(t < 400), 32'd1);
        if (t >= 400) return;
        if (exp_gap >= 0) chk("idle_gap", t, exp_gap);
        for (int c = 0; c < total; c++) begin
            slot = c / cpb;
            v = txd_v[s];
            if (c % cpb == 0) first_v = v;
            else if (v !== first_v) glitch++;
            if (slot == 0) begin
                if (v !== 1'b0) glitch++;
            end else if (slot <= 8) begin
                if (c % cpb == 0) dat[slot-1] = v;
            end else if (np != 0 && slot == 9) begin
                if (c % cpb == 0) pbit = v;
            end else if (v !== 1'b1) begin
                glitch++;
            end
            if (fd_v[s] === 1'b1) begin
                fd_cnt++;
                fd_pos = c;
            end
            step();
        end
        chk("busy_after_frame", busy_v[s], 1'b0);
        chk("txd_after_frame", txd_v[s], 1'b1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("data", dat, e.data);
        if (np != 0) chk("parity_bit", pbit, e.par);
        chk("level_glitches", glitch, 0);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_len", fd_pos + 1, e.len);
    endtask

    exp_t tv0 [4];
    exp_t tv1 [4];
    int   base;
    int   t;

    initial begin
        tv0[0] = '{8'h55, 1'b0, 40};
        tv0[1] = '{8'h00, 1'b0, 40};
        tv0[2] = '{8'hFF, 1'b0, 40};
        tv0[3] = '{8'hA3, 1'b0, 40};
        tv1[0] = '{8'h07, 1'b1, 44};
        tv1[1] = '{8'h03, 1'b0, 44};
        tv1[2] = '{8'hFF, 1'b0, 44};
        tv1[3] = '{8'h80, 1'b1, 44};
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0;
            empty_v[i] = 1'b1;
            rd[i] = '0;
        end

        // Reset state, with data waiting and en high.
        repeat (3) step();
        en_v[0] = 1'b1;
        push(0, tv0[0].data, tv0[0].par, tv0[0].len);
        #1;
        chk("rst_rq", rq_v[0], 1'b0);
        chk("rst_txd", txd_v[0], 1'b1);
        chk("rst_busy", busy_v[0], 1'b0);
        chk("rst_frame_done", fd_v[0], 1'b0);
        chk("rst_state", u0.state_q, IDLE);
        rst = 1'b0;
        #1;
        chk("rq_after_rst", rq_v[0], 1'b1);
        recv(0, -1);
        chk("single_rq_pulses", rq_cnt[0], 1);

        for (int i = 1; i < 4; i++) begin
            push(0, tv0[i].data, tv0[i].par, tv0[i].len);
            recv(0, -1);
        end

        en_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(1, tv1[i].data, tv1[i].par, tv1[i].len);
            recv(1, -1);
        end
        chk("parity_rq_pulses", rq_cnt[1], 4);

        // Back-to-back frames.
        base = rq_cnt[0];
        push(0, 8'h10, 1'b0, 40);
        push(0, 8'h20, 1'b0, 40);
        push(0, 8'h30, 1'b0, 40);
        recv(0, -1);
        recv(0, 2);
        recv(0, 2);
        chk("b2b_rq_pulses", rq_cnt[0] - base, 3);
        chk("b2b_empty", empty_v[0], 1'b1);
        chk("rq_never_consecutive", consec[0], 0);

        // en drops mid-frame.
        push(0, 8'hA5, 1'b0, 40);
        push(0, 8'h5A, 1'b0, 40);
        en_drop_cnt = 12;
        recv(0, -1);
        base = rq_cnt[0];
        repeat (20) step();
        chk("en_low_no_rq", rq_cnt[0] - base, 0);
        chk("en_low_busy", busy_v[0], 1'b0);
        chk("en_low_empty", empty_v[0], 1'b0);
        en_v[0] = 1'b1;
        recv(0, -1);

        // Reset during data bit 3: first byte lost, next byte sent intact.
        push(0, 8'hC3, 1'b0, 40);
        push(0, 8'h3C, 1'b0, 40);
        t = 0;
        while (txd_v[0] !== 1'b0 && t < 50) begin
            step();
            t++;
        end
        chk("rst_test_start", 32'(t < 50), 32'd1);
        repeat (4 + 12 + 2) step();
        chk("rst_test_in_data", u0.state_q, DATA);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_txd", txd_v[0], 1'b1);
        chk("midrst_busy", busy_v[0], 1'b0);
        chk("midrst_state", u0.state_q, IDLE);
        chk("midrst_rq", rq_v[0], 1'b0);
        step();
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        recv(0, -1);

        // Two stop bits at 2 clocks per bit.
        en_v[2] = 1'b1;
        push(2, 8'h96, 1'b0, 22);
        recv(2, -1);
        push(2, 8'h01, 1'b0, 22);
        recv(2, -1);

        // Empty FIFO: line stays idle.
        repeat (10) step();
        chk("empty_idle_txd", txd_v[0], 1'b1);
        chk("empty_idle_rq", rq_v[0], 1'b0);
        chk("empty_idle_busy", busy_v[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
